// File: rtl/mmu_pager_if.sv
// CPU-side bus of the mmu_pager: access strobe, address/data in, translation results out.
interface mmu_pager_if #(
    parameter int unsigned VADDR_W   = 16,
    parameter int unsigned PAGE_BITS = 13,
    parameter int unsigned FRAME_W   = 6,
    parameter int unsigned CTX_W     = 2
);
    logic                         i_valid;
    logic                         i_rw;
    logic [VADDR_W-1:0]           i_vadr;
    logic [7:0]                   i_wdata;
    logic                         o_valid;
    logic [FRAME_W+PAGE_BITS-1:0] o_padr;
    logic                         o_ramcs_n;
    logic                         o_romcs_n;
    logic [7:0]                   o_rdata;
    logic                         o_rdvalid;
    logic                         o_fault;
    logic                         o_nmi_n;
    logic [CTX_W-1:0]             o_ctx;

    modport master (
        output i_valid, i_rw, i_vadr, i_wdata,
        input  o_valid, o_padr, o_ramcs_n, o_romcs_n, o_rdata, o_rdvalid,
               o_fault, o_nmi_n, o_ctx
    );

    modport slave (
        input  i_valid, i_rw, i_vadr, i_wdata,
        output o_valid, o_padr, o_ramcs_n, o_romcs_n, o_rdata, o_rdvalid,
               o_fault, o_nmi_n, o_ctx
    );
endinterface

// File: rtl/mmu_pager.sv
// Paged MMU / address decoder: per-context page tables, ROM/RAM/IO decode, fault capture.
// Optional macro MMU_FAULT_ADDR_EN latches the faulting virtual address (readable at PAGES+2/+3).
module mmu_pager #(
    parameter int unsigned VADDR_W   = 16,
    parameter int unsigned PAGE_BITS = 13,
    parameter int unsigned FRAME_W   = 6,
    parameter int unsigned NCTX      = 4,
    parameter int unsigned IO_BASE   = 32'hFE00,
    parameter int unsigned ROM_BASE  = 32'hC000
) (
    input  logic       i_clk,
    input  logic       i_reset,
    mmu_pager_if.slave bus
);
    localparam int unsigned PAGE_W   = VADDR_W - PAGE_BITS;
    localparam int unsigned PAGES    = 1 << PAGE_W;
    localparam int unsigned CTX_W    = $clog2(NCTX);
    localparam int unsigned PADR_W   = FRAME_W + PAGE_BITS;
    localparam int unsigned IO_SPAN  = 256;
    localparam int unsigned OFF_CTRL = PAGES;
    localparam int unsigned OFF_STAT = PAGES + 1;
    localparam int unsigned OFF_FAL  = PAGES + 2;
    localparam int unsigned OFF_FAH  = PAGES + 3;
    localparam logic [7:0]  ENTRY_MASK = 8'hC0 | 8'((1 << FRAME_W) - 1);

    logic [7:0]        tbl [NCTX][PAGES];
    logic              rom_en;
    logic [CTX_W-1:0]  ctx;
    logic              pending;
    logic              st_cause;
    logic [PAGE_W-1:0] st_page;
    logic              nmi_n;
`ifdef MMU_FAULT_ADDR_EN
    logic [VADDR_W-1:0] fault_adr;
`endif

    logic              in_io;
    logic              in_rom;
    logic [7:0]        off;
    logic [PAGE_W-1:0] page;
    logic [7:0]        entry;
    logic              fault_c;
    logic              cause_c;
    logic [7:0]        rd_c;
    logic              st_set;
    logic              st_clr;
    logic              pending_nxt;

    // Address decode, translation lookup and register read mux
    always_comb begin
        in_io   = (32'(bus.i_vadr) >= IO_BASE) && (32'(bus.i_vadr) < IO_BASE + IO_SPAN);
        off     = 8'(32'(bus.i_vadr) - IO_BASE);
        in_rom  = !in_io && rom_en && (32'(bus.i_vadr) >= ROM_BASE);
        page    = bus.i_vadr[VADDR_W-1:PAGE_BITS];
        entry   = tbl[ctx][page];
        fault_c = !in_io && !in_rom && (entry[7] || (entry[6] && !bus.i_rw));
        cause_c = !entry[7];

        rd_c = 8'h00;
        if (32'(off) < PAGES) begin
            rd_c = tbl[ctx][off[PAGE_W-1:0]];
        end else if (32'(off) == OFF_CTRL) begin
            rd_c    = 8'(ctx);
            rd_c[7] = rom_en;
        end else if (32'(off) == OFF_STAT) begin
            rd_c = {pending, st_cause, 2'b00, 4'(st_page)};
`ifdef MMU_FAULT_ADDR_EN
        end else if (32'(off) == OFF_FAL) begin
            rd_c = 16'(fault_adr) & 16'h00FF;
        end else if (32'(off) == OFF_FAH) begin
            rd_c = 8'(16'(fault_adr) >> 8);
`endif
        end

        // A new fault takes priority over a status clear
        st_set      = bus.i_valid && fault_c && !pending;
        st_clr      = bus.i_valid && in_io && !bus.i_rw && (32'(off) == OFF_STAT);
        pending_nxt = pending;
        if (st_set) begin
            pending_nxt = 1'b1;
        end else if (st_clr) begin
            pending_nxt = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            bus.o_valid   <= 1'b0;
            bus.o_padr    <= '0;
            bus.o_ramcs_n <= 1'b1;
            bus.o_romcs_n <= 1'b1;
            bus.o_rdata   <= 8'h00;
            bus.o_rdvalid <= 1'b0;
            bus.o_fault   <= 1'b0;
            nmi_n         <= 1'b1;
            rom_en        <= 1'b1;
            ctx           <= '0;
            pending       <= 1'b0;
            st_cause      <= 1'b0;
            st_page       <= '0;
`ifdef MMU_FAULT_ADDR_EN
            fault_adr     <= '0;
`endif
            for (int c = 0; c < NCTX; c++) begin
                for (int p = 0; p < PAGES; p++) begin
                    tbl[CTX_W'(c)][PAGE_W'(p)] <= (c == 0) ? 8'(p) : 8'h80;
                end
            end
        end else begin
            bus.o_valid   <= bus.i_valid;
            bus.o_ramcs_n <= 1'b1;
            bus.o_romcs_n <= 1'b1;
            bus.o_rdvalid <= 1'b0;
            bus.o_fault   <= 1'b0;
            pending       <= pending_nxt;
            nmi_n         <= !pending_nxt;

            if (st_set) begin
                st_cause  <= cause_c;
                st_page   <= page;
`ifdef MMU_FAULT_ADDR_EN
                fault_adr <= bus.i_vadr;
`endif
            end else if (st_clr) begin
                st_cause <= 1'b0;
                st_page  <= '0;
            end

            if (bus.i_valid) begin
                if (in_io) begin
                    bus.o_padr <= '0;
                    if (bus.i_rw) begin
                        bus.o_rdvalid <= 1'b1;
                        bus.o_rdata   <= rd_c;
                    end else if (32'(off) < PAGES) begin
                        tbl[ctx][off[PAGE_W-1:0]] <= bus.i_wdata & ENTRY_MASK;
                    end else if (32'(off) == OFF_CTRL) begin
                        rom_en <= bus.i_wdata[7];
                        ctx    <= bus.i_wdata[CTX_W-1:0];
                    end
                end else if (in_rom) begin
                    bus.o_romcs_n <= 1'b0;
                    bus.o_padr    <= PADR_W'(bus.i_vadr);
                end else begin
                    bus.o_padr <= {entry[FRAME_W-1:0], bus.i_vadr[PAGE_BITS-1:0]};
                    if (fault_c) begin
                        bus.o_fault <= 1'b1;
                    end else begin
                        bus.o_ramcs_n <= 1'b0;
                    end
                end
            end
        end
    end

    assign bus.o_nmi_n = nmi_n;
    assign bus.o_ctx   = ctx;
endmodule

// File: tb/tb_mmu_pager.sv
// Directed self-checking bench for mmu_pager: translation, decode, register window, faults, reset.
module tb_mmu_pager;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    mmu_pager_if bus ();

    mmu_pager dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One bus access; outputs are sampled on the following falling edge
    task automatic acc(input logic rw, input logic [15:0] va, input logic [7:0] wd);
        @(negedge clk);
        bus.i_valid = 1'b1;
        bus.i_rw    = rw;
        bus.i_vadr  = va;
        bus.i_wdata = wd;
        @(negedge clk);
        bus.i_valid = 1'b0;
    endtask

    task automatic rd_reg(input string tag, input logic [15:0] va, input logic [7:0] exp);
        acc(1'b1, va, 8'h00);
        check({tag, ".rdvalid"}, 32'(bus.o_rdvalid), 32'd1);
        check(tag, 32'(bus.o_rdata), 32'(exp));
    endtask

    initial begin
        logic [7:0] fal_exp;
        logic [7:0] fah_exp;
        bus.i_valid = 1'b0;
        bus.i_rw    = 1'b1;
        bus.i_vadr  = 16'h0000;
        bus.i_wdata = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        check("rst.valid", 32'(bus.o_valid), 32'd0);
        check("rst.ramcs", 32'(bus.o_ramcs_n), 32'd1);
        check("rst.romcs", 32'(bus.o_romcs_n), 32'd1);
        check("rst.nmi", 32'(bus.o_nmi_n), 32'd1);
        check("rst.padr", 32'(bus.o_padr), 32'h0);
        check("rst.ctx", 32'(bus.o_ctx), 32'd0);

        // identity RAM translation
        acc(1'b1, 16'h2345, 8'h00);
        check("t1.valid", 32'(bus.o_valid), 32'd1);
        check("t1.padr", 32'(bus.o_padr), 32'h02345);
        check("t1.ramcs", 32'(bus.o_ramcs_n), 32'd0);
        check("t1.romcs", 32'(bus.o_romcs_n), 32'd1);
        check("t1.fault", 32'(bus.o_fault), 32'd0);
        @(negedge clk);
        check("idle.valid", 32'(bus.o_valid), 32'd0);
        check("idle.ramcs", 32'(bus.o_ramcs_n), 32'd1);

        // remap page 1
        acc(1'b0, 16'hFE01, 8'h25);
        check("t2.wr.ramcs", 32'(bus.o_ramcs_n), 32'd1);
        check("t2.wr.rdvalid", 32'(bus.o_rdvalid), 32'd0);
        acc(1'b1, 16'h3FFF, 8'h00);
        check("t2.padr", 32'(bus.o_padr), 32'h4BFFF);
        check("t2.ramcs", 32'(bus.o_ramcs_n), 32'd0);
        rd_reg("t2.entry1", 16'hFE01, 8'h25);

        // ROM decode and ROM disable
        acc(1'b1, 16'hD000, 8'h00);
        check("t3.romcs", 32'(bus.o_romcs_n), 32'd0);
        check("t3.ramcs", 32'(bus.o_ramcs_n), 32'd1);
        check("t3.rompadr", 32'(bus.o_padr), 32'h0D000);
        acc(1'b0, 16'hFE08, 8'h00);
        acc(1'b1, 16'hD000, 8'h00);
        check("t3.off.ramcs", 32'(bus.o_ramcs_n), 32'd0);
        check("t3.off.romcs", 32'(bus.o_romcs_n), 32'd1);
        check("t3.off.padr", 32'(bus.o_padr), 32'h0D000);
        rd_reg("t3.ctrl", 16'hFE08, 8'h00);

        // control readback masks unused bits
        acc(1'b0, 16'hFE08, 8'hFF);
        check("ctrl.ctx3", 32'(bus.o_ctx), 32'd3);
        rd_reg("ctrl.mask", 16'hFE08, 8'h83);

        // invalid page fault in context 1
        acc(1'b0, 16'hFE08, 8'h81);
        check("t4.ctx", 32'(bus.o_ctx), 32'd1);
        acc(1'b1, 16'h0000, 8'h00);
        check("t4.fault", 32'(bus.o_fault), 32'd1);
        check("t4.ramcs", 32'(bus.o_ramcs_n), 32'd1);
        check("t4.nmi", 32'(bus.o_nmi_n), 32'd0);
        check("t4.padr", 32'(bus.o_padr), 32'h0);
        rd_reg("t4.status", 16'hFE09, 8'h80);
        rd_reg("t4.fal", 16'hFE0A, 8'h00);
        rd_reg("t4.fah", 16'hFE0B, 8'h00);
        // ROM boundary: C000 is ROM, BFFF goes through invalid page 5
        acc(1'b1, 16'hC000, 8'h00);
        check("rom.c000.romcs", 32'(bus.o_romcs_n), 32'd0);
        check("rom.c000.fault", 32'(bus.o_fault), 32'd0);
        acc(1'b1, 16'hBFFF, 8'h00);
        check("rom.bfff.fault", 32'(bus.o_fault), 32'd1);
        check("rom.bfff.romcs", 32'(bus.o_romcs_n), 32'd1);
        rd_reg("t4.held", 16'hFE09, 8'h80);
        acc(1'b0, 16'hFE09, 8'h00);
        check("t4.clr.nmi", 32'(bus.o_nmi_n), 32'd1);
        rd_reg("t4.clr.status", 16'hFE09, 8'h00);
        acc(1'b0, 16'hBFFF, 8'h00);
        check("fa.fault", 32'(bus.o_fault), 32'd1);
        rd_reg("fa.status", 16'hFE09, 8'h85);
`ifdef MMU_FAULT_ADDR_EN
        fal_exp = 8'hFF;
        fah_exp = 8'hBF;
`else
        fal_exp = 8'h00;
        fah_exp = 8'h00;
`endif
        acc(1'b0, 16'hFE0A, 8'h12);
        rd_reg("fa.lo", 16'hFE0A, fal_exp);
        rd_reg("fa.hi", 16'hFE0B, fah_exp);

        // beyond-register offsets inside the window
        acc(1'b0, 16'hFE0C, 8'h55);
        rd_reg("io.fe0c", 16'hFE0C, 8'h00);
        check("io.fe0c.ramcs", 32'(bus.o_ramcs_n), 32'd1);
        check("io.fe0c.romcs", 32'(bus.o_romcs_n), 32'd1);
        rd_reg("io.fe20", 16'hFE20, 8'h00);

        // write-protect fault in context 0
        acc(1'b0, 16'hFE08, 8'h80);
        acc(1'b0, 16'hFE09, 8'h00);
        acc(1'b0, 16'hFE02, 8'h42);
        acc(1'b0, 16'h4000, 8'hAA);
        check("t5.fault", 32'(bus.o_fault), 32'd1);
        check("t5.ramcs", 32'(bus.o_ramcs_n), 32'd1);
        check("t5.nmi", 32'(bus.o_nmi_n), 32'd0);
        rd_reg("t5.status", 16'hFE09, 8'hC2);
        acc(1'b1, 16'h4000, 8'h00);
        check("t5.rd.padr", 32'(bus.o_padr), 32'h04000);
        check("t5.rd.fault", 32'(bus.o_fault), 32'd0);
        check("t5.rd.ramcs", 32'(bus.o_ramcs_n), 32'd0);
        acc(1'b0, 16'h4000, 8'hAA);
        check("t5.2nd.fault", 32'(bus.o_fault), 32'd1);
        rd_reg("t5.2nd.status", 16'hFE09, 8'hC2);
        // clear then immediately re-fault: pending must end set
        acc(1'b0, 16'hFE09, 8'h00);
        acc(1'b0, 16'h4000, 8'hAA);
        check("t5.race.nmi", 32'(bus.o_nmi_n), 32'd0);
        rd_reg("t5.race.status", 16'hFE09, 8'hC2);

        // reset with a pending fault in context 1
        acc(1'b0, 16'hFE01, 8'h3F);
        acc(1'b0, 16'hFE08, 8'h01);
        acc(1'b1, 16'h0000, 8'h00);
        check("t6.nmi.pre", 32'(bus.o_nmi_n), 32'd0);
        @(negedge clk);
        rst         = 1'b1;
        bus.i_valid = 1'b1;
        bus.i_rw    = 1'b1;
        bus.i_vadr  = 16'h2000;
        @(negedge clk);
        rst         = 1'b0;
        bus.i_valid = 1'b0;
        check("t6.valid", 32'(bus.o_valid), 32'd0);
        check("t6.nmi", 32'(bus.o_nmi_n), 32'd1);
        check("t6.ctx", 32'(bus.o_ctx), 32'd0);
        rd_reg("t6.ctrl", 16'hFE08, 8'h80);
        rd_reg("t6.entry1", 16'hFE01, 8'h01);
        rd_reg("t6.status", 16'hFE09, 8'h00);
        acc(1'b1, 16'hD000, 8'h00);
        check("t6.romcs", 32'(bus.o_romcs_n), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
